// File: rtl/ahb_music_tone_gen.sv
// Square-wave tone generator driven by the MUSIC command word: plays a note of
// HALF_PER-cycle half-period for DUR_MS ticks, then a silent gap, then pulses NOTE_DONE.
module ahb_music_tone_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1_000,
  parameter int GAP_TICKS   = 10
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] MUSIC,
  output logic        BUZZER,
  output logic        BUSY,
  output logic        NOTE_DONE
);
  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        r_state;
  logic [31:0]   r_mus_q;
  logic [17:0]   r_hp;
  logic [17:0]   r_div;
  logic [11:0]   r_dur;
  logic [TW-1:0] r_tick;
  logic [GW-1:0] r_gap;

  logic w_cmd, w_en, w_tick;

  // Any change of the word is a command; SEQ exists so identical notes still differ.
  assign w_cmd  = (MUSIC != r_mus_q);
  assign w_en   = MUSIC[31];
  assign w_tick = (r_tick == TW'(TICK_DIV - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= IDLE;
      r_mus_q   <= '0;
      r_hp      <= '0;
      r_div     <= '0;
      r_dur     <= '0;
      r_tick    <= '0;
      r_gap     <= '0;
      BUZZER    <= 1'b0;
      BUSY      <= 1'b0;
      NOTE_DONE <= 1'b0;
    end else begin
      r_mus_q   <= MUSIC;
      NOTE_DONE <= 1'b0;
      if (r_state != IDLE)
        r_tick <= w_tick ? '0 : r_tick + 1'b1;

      if (w_cmd) begin
        // A command overrides any expiry on the same edge, so no NOTE_DONE here.
        BUZZER <= 1'b0;
        r_div  <= '0;
        r_tick <= '0;
        r_gap  <= '0;
        if (w_en) begin
          r_state <= PLAY;
          BUSY    <= 1'b1;
          r_hp    <= MUSIC[17:0];
          r_dur   <= MUSIC[29:18];
        end else begin
          r_state <= IDLE;
          BUSY    <= 1'b0;
        end
      end else begin
        case (r_state)
          PLAY: begin
            if (r_hp != 18'd0) begin
              if (r_div == r_hp - 18'd1) begin
                BUZZER <= ~BUZZER;
                r_div  <= '0;
              end else begin
                r_div <= r_div + 18'd1;
              end
            end
            // r_dur==0 means an untimed note that plays until the next command.
            if (w_tick && r_dur != 12'd0) begin
              if (r_dur == 12'd1) begin
                r_state <= GAP;
                BUZZER  <= 1'b0;
                r_gap   <= GW'(GAP_TICKS);
                r_dur   <= '0;
              end else begin
                r_dur <= r_dur - 12'd1;
              end
            end
          end
          GAP: begin
            if (r_gap == '0 || (w_tick && r_gap == GW'(1))) begin
              r_state   <= IDLE;
              BUSY      <= 1'b0;
              NOTE_DONE <= 1'b1;
            end else if (w_tick) begin
              r_gap <= r_gap - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ahb_music_tone_gen.sv
// Scoreboarded bench: a note-level arithmetic model predicts outputs per cycle,
// a monitor compares them against the DUT one time unit after each edge.
module tb_ahb_music_tone_gen;
  localparam int TD = 10;  // TICK_DIV for the bench parameters
  localparam int G  = 1;   // GAP_TICKS

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] MUSIC = '0;
  logic        BUZZER, BUSY, NOTE_DONE;

  ahb_music_tone_gen #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .GAP_TICKS(G)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .MUSIC(MUSIC),
    .BUZZER(BUZZER), .BUSY(BUSY), .NOTE_DONE(NOTE_DONE)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic buz;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: last word seen, whether a note is running, its load edge and fields.
  logic [31:0] m_q = '0;
  bit          m_act = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          m_hp = 0;
  int          m_dur = 0;

  function automatic logic [31:0] note(input bit seq, input int dur, input int hp);
    note = {1'b1, seq, 12'(dur), 18'(hp)};
  endfunction

  task automatic step(input logic [31:0] w, input bit rst);
    exp_t e;
    int   k, endk;
    @(negedge HCLK);
    MUSIC  = w;
    HRESET = rst;
    cyc++;
    e = '0;
    if (rst) begin
      m_q   = '0;
      m_act = 0;
    end else begin
      if (w != m_q) begin
        m_act = w[31];
        t0    = cyc;
        m_hp  = int'(w[17:0]);
        m_dur = int'(w[29:18]);
      end
      m_q = w;
      if (m_act) begin
        k    = cyc - t0;
        endk = (m_dur + G) * TD;
        if (m_dur == 0 || k < m_dur * TD)
          e.buz = (m_hp != 0) && (((k / m_hp) % 2) == 1);
        e.busy = (m_dur == 0) || (k < endk);
        e.done = (m_dur != 0) && (k == endk);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) step(w, 1'b0);
  endtask

  always @(posedge HCLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({BUZZER, BUSY, NOTE_DONE} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t buz/busy/done got %b%b%b expected %b%b%b",
                 $time, BUZZER, BUSY, NOTE_DONE, e.buz, e.busy, e.done);
      end
    end
  end

  initial begin
    logic [31:0] w;
    int r;
    // Reset state, then quiet idle cycles.
    step('0, 1'b1);
    step('0, 1'b1);
    hold('0, 3);
    // Timed note, held well past NOTE_DONE; rewriting the same word does nothing.
    w = note(1'b0, 3, 2);
    hold(w, 55);
    // SEQ flip replays the same note.
    w[30] = ~w[30];
    hold(w, 45);
    // Abort mid-note with an untimed note.
    w[30] = ~w[30];
    hold(w, 12);
    hold(note(1'b0, 0, 5), 40);
    // Disable during an untimed note.
    hold('0, 5);
    hold(note(1'b1, 2, 3), 8);
    hold(32'h0000_0003, 6);
    // Rest note: silent but timed.
    hold(note(1'b0, 2, 0), 35);
    // hp=1 toggles every cycle.
    hold(note(1'b1, 1, 1), 25);
    // Reset mid-note with the word held nonzero.
    w = note(1'b1, 2, 3);
    hold(w, 15);
    step(w, 1'b1);
    step(w, 1'b1);
    step(w, 1'b1);
    hold(w, 40);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      w = note(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6));
        else if (r == 6) w[30] = ~w[30];
        else if (r == 7) w = {1'b0, 31'($urandom_range(0, 32'h7fff))};
        if (r == 9) begin
          for (int j = 0; j < $urandom_range(1, 3); j++) step(w, 1'b1);
        end else begin
          step(w, 1'b0);
        end
      end else begin
        step(w, 1'b0);
      end
    end
    repeat (2) @(posedge HCLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
